// File: rtl/rtimer_ctrl.sv
// rtimer_ctrl: BCD timer with button-edited preset. It counts down from the preset, or up from
// zero to the preset, one centisecond per clock. It signals the terminal count on a blinking
// output.
module rtimer_ctrl #(
  parameter logic [7:0]  DEF_MIN     = 8'h05,
  parameter logic [7:0]  DEF_SEC     = 8'h00,
  parameter logic [7:0]  DEF_MS10    = 8'h00,
  parameter logic [7:0]  MIN_LIMIT   = 8'h99,
  parameter bit          AUTO_RELOAD = 1'b0,
  parameter int unsigned BLINK_TICKS = 50
) (
  input  logic       clk_core,
  input  logic       rst,
  input  logic       left_button,
  input  logic       right_button,
  input  logic       up_button,
  input  logic       down_button,
  input  logic       center_button,
  input  logic       mode_i,
  output logic [7:0] min_o,
  output logic [7:0] sec_o,
  output logic [7:0] ms_10_o,
  output logic [1:0] target,
  output logic       running_o,
  output logic       time_out_o
);

  typedef enum logic [1:0] {StSet, StRun, StPause, StDone} state_e;

  localparam logic [7:0] BlinkLast = 8'(BLINK_TICKS - 1);

  // BCD +1 with wrap to 00 past lim.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
    if (v == lim) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return v + 8'd1;
  endfunction

  // BCD -1 with wrap from 00 to lim.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] lim);
    if (v == 8'h00) return lim;
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    return v - 8'd1;
  endfunction

  state_e      state_q, state_d;
  logic [1:0]  target_q, target_d;
  logic [7:0]  pre_min_q, pre_min_d;
  logic [7:0]  pre_sec_q, pre_sec_d;
  logic [7:0]  pre_ms_q, pre_ms_d;
  logic [23:0] cnt_q, cnt_d;
  logic        mode_q, mode_d;
  logic        tout_q, tout_d;
  logic [7:0]  blink_q, blink_d;
  logic [4:0]  btn_prev_q;

  logic [4:0]  btn, press;
  logic [2:0]  dir_count;
  logic        single, c_ev, l_ev, r_ev, u_ev, d_ev;
  logic [23:0] preset_all, reload_val, tick;
  logic [7:0]  tick_min, tick_sec, tick_ms;
  logic        tick_done;

  assign btn   = {center_button, left_button, right_button, up_button, down_button};
  assign press = btn & ~btn_prev_q;

  // Simultaneous directional presses cancel each other; center beats everything.
  assign dir_count = 3'(press[3]) + 3'(press[2]) + 3'(press[1]) + 3'(press[0]);
  assign single    = (dir_count == 3'd1) && !press[4];
  assign c_ev      = press[4];
  assign l_ev      = single & press[3];
  assign r_ev      = single & press[2];
  assign u_ev      = single & press[1];
  assign d_ev      = single & press[0];

  assign preset_all = {pre_min_q, pre_sec_q, pre_ms_q};
  assign reload_val = mode_q ? 24'h0 : preset_all;

  // One-centisecond step of the running counter with BCD carry/borrow.
  always_comb begin
    tick_ms  = cnt_q[7:0];
    tick_sec = cnt_q[15:8];
    tick_min = cnt_q[23:16];
    if (mode_q) begin
      tick_ms = bcd_inc(cnt_q[7:0], 8'h99);
      if (cnt_q[7:0] == 8'h99) begin
        tick_sec = bcd_inc(cnt_q[15:8], 8'h59);
        if (cnt_q[15:8] == 8'h59) tick_min = bcd_inc(cnt_q[23:16], MIN_LIMIT);
      end
    end else begin
      tick_ms = bcd_dec(cnt_q[7:0], 8'h99);
      if (cnt_q[7:0] == 8'h00) begin
        tick_sec = bcd_dec(cnt_q[15:8], 8'h59);
        if (cnt_q[15:8] == 8'h00) tick_min = bcd_dec(cnt_q[23:16], MIN_LIMIT);
      end
    end
  end

  assign tick      = {tick_min, tick_sec, tick_ms};
  assign tick_done = mode_q ? (tick == preset_all) : (tick == 24'h0);

  // Next-state and datapath updates for the SET/RUN/PAUSE/DONE controller.
  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    pre_min_d = pre_min_q;
    pre_sec_d = pre_sec_q;
    pre_ms_d  = pre_ms_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    tout_d    = tout_q;
    blink_d   = blink_q;
    unique case (state_q)
      StSet: begin
        if (c_ev) begin
          // An all-zero preset would finish instantly, so the start press is ignored.
          if (preset_all != 24'h0) begin
            state_d = StRun;
            mode_d  = mode_i;
            cnt_d   = mode_i ? 24'h0 : preset_all;
          end
        end else if (l_ev) begin
          if (target_q != 2'b10) target_d = target_q + 2'd1;
        end else if (r_ev) begin
          if (target_q != 2'b00) target_d = target_q - 2'd1;
        end else if (u_ev || d_ev) begin
          case (target_q)
            2'b00:   pre_ms_d  = u_ev ? bcd_inc(pre_ms_q, 8'h99) : bcd_dec(pre_ms_q, 8'h99);
            2'b01:   pre_sec_d = u_ev ? bcd_inc(pre_sec_q, 8'h59) : bcd_dec(pre_sec_q, 8'h59);
            default: pre_min_d = u_ev ? bcd_inc(pre_min_q, MIN_LIMIT)
                                      : bcd_dec(pre_min_q, MIN_LIMIT);
          endcase
        end
      end
      StRun: begin
        if (c_ev) begin
          state_d = StPause;
        end else if (r_ev) begin
          cnt_d = reload_val;
        end else begin
          cnt_d = tick;
          if (tick_done) begin
            state_d = StDone;
            tout_d  = 1'b1;
            blink_d = 8'd0;
          end
        end
      end
      StPause: begin
        if (c_ev) begin
          state_d = StRun;
        end else if (r_ev) begin
          state_d  = StSet;
          target_d = 2'b01;
        end
      end
      StDone: begin
        if (AUTO_RELOAD) begin
          state_d = StRun;
          cnt_d   = reload_val;
          tout_d  = 1'b0;
          blink_d = 8'd0;
        end else if (c_ev || r_ev) begin
          state_d  = StSet;
          target_d = 2'b01;
          tout_d   = 1'b0;
          blink_d  = 8'd0;
        end else if (blink_q == BlinkLast) begin
          blink_d = 8'd0;
          tout_d  = ~tout_q;
        end else begin
          blink_d = blink_q + 8'd1;
        end
      end
    endcase
  end

  // State registers; reset aborts any activity immediately.
  always_ff @(posedge clk_core or posedge rst) begin
    if (rst) begin
      state_q    <= StSet;
      target_q   <= 2'b01;
      pre_min_q  <= DEF_MIN;
      pre_sec_q  <= DEF_SEC;
      pre_ms_q   <= DEF_MS10;
      cnt_q      <= 24'h0;
      mode_q     <= 1'b0;
      tout_q     <= 1'b0;
      blink_q    <= 8'd0;
      btn_prev_q <= 5'h1f;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      pre_min_q  <= pre_min_d;
      pre_sec_q  <= pre_sec_d;
      pre_ms_q   <= pre_ms_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      tout_q     <= tout_d;
      blink_q    <= blink_d;
      btn_prev_q <= btn;
    end
  end

  // Display shows the preset while editing, the counter otherwise.
  always_comb begin
    if (state_q == StSet) begin
      {min_o, sec_o, ms_10_o} = preset_all;
      target                  = target_q;
    end else begin
      {min_o, sec_o, ms_10_o} = cnt_q;
      target                  = 2'b11;
    end
  end

  assign running_o  = (state_q == StRun);
  assign time_out_o = tout_q;

endmodule

// File: doc/rtimer_ctrl.md
RTIMER_CTRL -- requirements
Module: rtimer_ctrl

Interface
REQ-001 Parameter DEF_MIN, default 8'h05, BCD preset minutes loaded at reset.
REQ-002 Parameter DEF_SEC, default 8'h00, BCD preset seconds loaded at reset.
REQ-003 Parameter DEF_MS10, default 8'h00, BCD preset centiseconds loaded at reset.
REQ-004 Parameter MIN_LIMIT, default 8'h99, BCD upper bound of the minutes field.
REQ-005 Parameter AUTO_RELOAD, default 0; when 1, DONE restarts automatically.
REQ-006 Parameter BLINK_TICKS, default 50, clk_core cycles per time_out_o toggle; range 1..255.
REQ-007 clk_core  in  1  100 Hz system clock; all state changes on its rising edge.
REQ-008 rst  in  1  reset; one clock, reset is asynchronous and active-high.
REQ-009 left_button, right_button, up_button, down_button, center_button  in  1 each  level button inputs.
REQ-010 mode_i  in  1  0 = countdown from preset, 1 = count-up from zero to preset.
REQ-011 min_o, sec_o, ms_10_o  out  8 each  BCD display value.
REQ-012 target  out  2  edit field: 00 ms_10, 01 sec, 10 min, 11 not editing.
REQ-013 running_o  out  1  high only in RUN.
REQ-014 time_out_o  out  1  terminal-count indication, blinking.

Function
REQ-015 Each button SHALL be edge-detected with a registered previous value; a press is button=1 and previous=0; one action per press.
REQ-016 Priority: center press overrides all others in the same cycle; two or more simultaneous presses among left/right/up/down SHALL be ignored.
REQ-017 FSM states SET, RUN, PAUSE, DONE; all transitions registered, one cycle after the press edge is sampled.
REQ-018 SET: left press increments target saturating at 10; right press decrements target saturating at 00.
REQ-019 SET: up/down press adjusts the selected preset field by 1 in BCD with wrap: ms_10 00..99, sec 00..59, min 00..MIN_LIMIT (up at limit -> 00; down at 00 -> limit).
REQ-020 SET: center press SHALL latch mode_i and go to RUN, loading counter = preset (countdown) or 00:00.00 (count-up); if preset is all zero the press is ignored and the FSM stays in SET.
REQ-021 RUN: counter changes by one centisecond per cycle starting the cycle after entry, BCD borrow/carry ms_10 -> sec (base 60) -> min.
REQ-022 RUN countdown: when the counter reaches 00:00.00 the FSM SHALL enter DONE on that same edge; count-up: when counter equals preset, enter DONE on that same edge.
REQ-023 RUN: center press -> PAUSE, counter held; right press -> counter reloaded per REQ-020, stays in RUN.
REQ-024 PAUSE: center press -> RUN, counting resumes from the held value; right press -> SET, preset unchanged; other presses ignored.
REQ-025 DONE: counter holds its terminal value; time_out_o is 1 on entry and toggles every BLINK_TICKS cycles.
REQ-026 DONE with AUTO_RELOAD=1: on the next cycle reload per REQ-020 and return to RUN; time_out_o is a one-cycle pulse.
REQ-027 DONE with AUTO_RELOAD=0: center or right press -> SET, time_out_o 0 on the same edge.
REQ-028 Outputs: in SET, min_o/sec_o/ms_10_o = preset; otherwise = counter. target = 11 outside SET and is restored to 01 on entry to SET.
REQ-029 mode_i is sampled only per REQ-020; changes in RUN/PAUSE/DONE have no effect.

Reset
REQ-030 While rst=1: state SET, target 01, preset = DEF_MIN/DEF_SEC/DEF_MS10, counter 00:00.00, time_out_o 0, running_o 0, blink counter 0.
REQ-031 Button previous-value registers SHALL reset to 1, so a button held through reset release produces no press.
REQ-032 Reset asserted mid-RUN or mid-DONE SHALL abort immediately to the REQ-030 values.

Verification
REQ-033 Reset, set target 00, down press on ms_10=00 -> ms_10_o 8'h99; up press -> 8'h00.
REQ-034 Preset 00:00.03, mode 0, center press -> RUN; counter reads 03, 02, 01, 00 on successive cycles; DONE and time_out_o=1 on the same edge as 00.
REQ-035 Preset 00:01.00, mode 1, run -> counter passes 00:00.99 -> 00:01.00 and enters DONE; time_out_o toggles after 50 cycles.
REQ-036 RUN, center -> PAUSE for 10 cycles (value constant), center -> RUN resumes from the same value; right in PAUSE -> SET showing the unchanged preset.
REQ-037 Left+up pressed in the same cycle in SET -> no change; center+left in the same cycle -> RUN only.
REQ-038 AUTO_RELOAD=1, preset 00:00.02 -> time_out_o is a 1-cycle pulse every 3 cycles; rst asserted mid-run -> all outputs at reset values.
